fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 32'h00010000, the first fetch address after reset.
REQ-002 Parameter: BUF_DEPTH, default 2, the fetch buffer entries; this is also the maximum number of outstanding requests.
REQ-003 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: redirect_valid  in  1  next-PC redirect (taken branch/JALR) from the NPC logic.
REQ-006 Port: redirect_pc  in  32  redirect target; used unmodified, alignment checked elsewhere.
REQ-007 Port: imem_req_valid  out  1  instruction memory request valid.
REQ-008 Port: imem_req_addr  out  32  request address (current fetch PC).
REQ-009 Port: imem_req_ready  in  1  memory accepts the request this cycle.
REQ-010 Port: imem_resp_valid  in  1  in-order response valid; responses are never back-pressured.
REQ-011 Port: imem_resp_data  in  32  response instruction word.
REQ-012 Port: inst_valid  out  1  buffer head valid toward decode.
REQ-013 Port: inst_data  out  32  buffer head instruction.
REQ-014 Port: inst_pc  out  32  PC of the buffer head instruction.
REQ-015 Port: inst_ready  in  1  decode consumes the head (stall when 0).

Function
REQ-016 The block SHALL have states BOOT, RUN and DRAIN; reset enters BOOT, and BOOT SHALL go to RUN after exactly one cycle with no request issued.
REQ-017 Request handshake: a request SHALL be issued when imem_req_valid and imem_req_ready are both 1; each issued request SHALL advance fetch_pc by 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
REQ-018 The block SHALL assert imem_req_valid only in RUN, and only when outstanding + occupancy < BUF_DEPTH (credit rule).
REQ-019 Once imem_req_valid is asserted, it and imem_req_addr SHALL hold stable until the handshake, unless a redirect occurs.
REQ-020 A PC tag FIFO SHALL record the address of each issued request; on each imem_resp_valid the response SHALL be written to the buffer tail with its tag and outstanding SHALL decrement.
REQ-021 The buffer head SHALL be consumed when inst_valid and inst_ready are both 1.
REQ-022 A response write and a head consume in the same cycle SHALL leave occupancy unchanged.
REQ-023 A response arriving to an empty buffer SHALL appear on inst_* in the next cycle; there is no bypass.
REQ-024 Redirect SHALL take priority over every other event in the same cycle.
REQ-025 On redirect, the block SHALL set fetch_pc to redirect_pc, clear the buffer (inst_valid=0 next cycle) and load drop_cnt with the requests still outstanding after this cycle's events; a request handshaken in the same cycle counts as stale, and a response arriving in the same cycle is discarded.
REQ-026 After a redirect the state SHALL be DRAIN if drop_cnt>0, else RUN.
REQ-027 In DRAIN, each response SHALL be discarded and decrement drop_cnt; the block SHALL go to RUN in the cycle after drop_cnt reaches 0.
REQ-028 A redirect in DRAIN SHALL update fetch_pc and keep draining.
REQ-029 A head consume in the redirect cycle SHALL be honoured; the rest of the buffer is dropped.
REQ-030 Counter and tag-FIFO overflow SHALL be impossible by the credit rule; a response with outstanding=0 SHALL be ignored.

Reset
REQ-031 Asserting rst (low) SHALL immediately produce: state BOOT, fetch_pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, buffer, tag FIFO, outstanding and drop_cnt all zero.
REQ-032 Reset asserted mid-transaction SHALL abandon all in-flight state.
REQ-033 After rst deasserts, the first request (0x10000) SHALL be presented in the second cycle.

Verification
REQ-034 Reset release with imem_req_ready=1, 1-cycle response latency, inst_ready=1: requests issue at 0x10000, 0x10004, 0x10008, and inst_pc follows the same sequence.
REQ-035 inst_ready=0 held: at most 2 requests issue, inst_valid stays 1 with inst_pc=0x10000, and imem_req_valid drops to 0 until a consume.
REQ-036 Redirect to 0x20040 with 2 requests outstanding: both responses are discarded in DRAIN, the next request address is 0x20040, and inst_valid stays 0 until its response.
REQ-037 Redirect coincident with a request handshake and a response: the response is dropped, drop_cnt counts the new request, and the first valid inst_pc is the redirect target.
REQ-038 redirect_pc=0xFFFFFFFC: requests issue at 0xFFFFFFFC then 0x00000000.
REQ-039 rst pulsed low with 2 requests outstanding: outputs return to reset values asynchronously; stale responses after release are ignored and fetch restarts at 0x10000.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: NPC redirect, instruction-memory request/response and
// the decode-facing instruction stream.
interface fetch_sequencer_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   // Handshakes: a request transfers on a clock edge where imem_req_valid and
   // imem_req_ready are both 1; once raised, valid and addr hold until that edge
   // unless a redirect occurs. An instruction transfers on an edge where
   // inst_valid and inst_ready are both 1. Responses have no ready and
   // return in request order.
   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready,
             imem_resp_valid, imem_resp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready,
             imem_resp_valid, imem_resp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Credit-limited instruction fetch sequencer: issues in-order fetches, tags each
// with its PC, buffers responses for decode and drains stale ones after a redirect.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0001_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   fetch_sequencer_if.master bus,
   output logic [1:0]        dbg_state_o
);
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
   logic [31:0]   tag_mem_q  [BUF_DEPTH];
   logic [31:0]   buf_data_q [BUF_DEPTH];
   logic [31:0]   buf_pc_q   [BUF_DEPTH];

   logic          req_valid, req_fire, tag_push;
   logic          resp_any, resp_keep, consume, inst_valid;
   logic [CW-1:0] pending, drop_calc;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // outstanding + occupancy never exceeds BUF_DEPTH, so neither FIFO can overflow
   assign inst_valid = (occ_q != '0);
   assign req_valid  = (state_q == S_RUN) && ((out_cnt_q + occ_q) < DEPTH_C);
   assign req_fire   = req_valid && bus.imem_req_ready;
   assign tag_push   = req_fire && !bus.redirect_valid;
   assign pending    = out_cnt_q + drop_cnt_q;
   assign resp_any   = bus.imem_resp_valid && (pending != '0);
   assign resp_keep  = resp_any && (state_q == S_RUN) && !bus.redirect_valid;
   assign consume    = inst_valid && bus.inst_ready && !bus.redirect_valid;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      out_cnt_d  = out_cnt_q;
      drop_cnt_d = drop_cnt_q;
      occ_d      = occ_q;
      tag_wr_d   = tag_wr_q;
      tag_rd_d   = tag_rd_q;
      buf_wr_d   = buf_wr_q;
      buf_rd_d   = buf_rd_q;
      drop_calc  = pending;

      case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            if (tag_push) begin
               tag_wr_d   = ptr_inc(tag_wr_q);
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_keep) begin
               tag_rd_d = ptr_inc(tag_rd_q);
               buf_wr_d = ptr_inc(buf_wr_q);
            end
            if (consume) buf_rd_d = ptr_inc(buf_rd_q);
            if (tag_push && !resp_keep)      out_cnt_d = out_cnt_q + CW'(1);
            else if (!tag_push && resp_keep) out_cnt_d = out_cnt_q - CW'(1);
            if (resp_keep && !consume)       occ_d = occ_q + CW'(1);
            else if (!resp_keep && consume)  occ_d = occ_q - CW'(1);
         end
         S_DRAIN: begin
            if (resp_any) begin
               drop_cnt_d = drop_cnt_q - CW'(1);
               if (drop_cnt_q == CW'(1)) state_d = S_RUN;
            end
         end
         default: state_d = S_BOOT;
      endcase

      // A request accepted this cycle is already stale; a returning response retires one.
      if (bus.redirect_valid) begin
         if (req_fire) drop_calc = drop_calc + CW'(1);
         if (resp_any) drop_calc = drop_calc - CW'(1);
         fetch_pc_d = bus.redirect_pc;
         out_cnt_d  = '0;
         drop_cnt_d = drop_calc;
         occ_d      = '0;
         tag_wr_d   = '0;
         tag_rd_d   = '0;
         buf_wr_d   = '0;
         buf_rd_d   = '0;
         state_d    = (drop_calc != '0) ? S_DRAIN : S_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         occ_q      <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         buf_wr_q   <= '0;
         buf_rd_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         occ_q      <= occ_d;
         tag_wr_q   <= tag_wr_d;
         tag_rd_q   <= tag_rd_d;
         buf_wr_q   <= buf_wr_d;
         buf_rd_q   <= buf_rd_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            tag_mem_q[i]  <= '0;
            buf_data_q[i] <= '0;
            buf_pc_q[i]   <= '0;
         end
      end else begin
         if (tag_push) tag_mem_q[tag_wr_q] <= fetch_pc_q;
         if (resp_keep) begin
            buf_data_q[buf_wr_q] <= bus.imem_resp_data;
            buf_pc_q[buf_wr_q]   <= tag_mem_q[tag_rd_q];
         end
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.inst_valid     = inst_valid;
   assign bus.inst_data      = buf_data_q[buf_rd_q];
   assign bus.inst_pc        = buf_pc_q[buf_rd_q];
   assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a queue-backed memory answering one cycle
// after each handshake with data = ~addr, and logs of issued and consumed fetches.
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic rst;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   fetch_sequencer_if bus();

   fetch_sequencer #(
      .RESET_PC  (32'h0001_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] iss_q[$];
   logic [31:0] pend_q[$];
   logic [31:0] cons_pc_q[$];
   logic [31:0] cons_d_q[$];
   bit resp_en   = 1'b0;
   bit flush_mem = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reset_dut();
      rst                = 1'b0;
      flush_mem          = 1'b1;
      resp_en            = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      tick(2);
      flush_mem = 1'b0;
      iss_q.delete();
      cons_pc_q.delete();
      cons_d_q.delete();
   endtask

   // Compares exp_q against the issue log (cons=0) or the consume log (cons=1).
   task automatic chk_log(input string tag, input bit cons);
      int n;
      n = cons ? cons_pc_q.size() : iss_q.size();
      chk({tag, "_count"}, 32'(n >= exp_q.size()), 32'd1);
      foreach (exp_q[i]) begin
         if (i < n) begin
            if (cons) begin
               chk($sformatf("%s_pc%0d", tag, i), cons_pc_q[i], exp_q[i]);
               chk($sformatf("%s_data%0d", tag, i), cons_d_q[i], ~exp_q[i]);
            end else begin
               chk($sformatf("%s_addr%0d", tag, i), iss_q[i], exp_q[i]);
            end
         end
      end
   endtask

   // Monitor: record handshakes at the active edge.
   initial begin
      forever begin
         @(posedge clk);
         if (rst === 1'b1) begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               iss_q.push_back(bus.imem_req_addr);
               pend_q.push_back(bus.imem_req_addr);
            end
            if (bus.inst_valid && bus.inst_ready) begin
               cons_pc_q.push_back(bus.inst_pc);
               cons_d_q.push_back(bus.inst_data);
            end
         end
      end
   end

   // Memory responder: one response per cycle, sampled at the following edge.
   initial begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         if (flush_mem) begin
            pend_q.delete();
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
         end else if (resp_en && pend_q.size() > 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = ~pend_q.pop_front();
         end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
         end
      end
   end

   initial begin
      // Reset values and boot timing, then streaming fetch
      reset_dut();
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_req_addr", bus.imem_req_addr, 32'h0001_0000);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst_data", bus.inst_data, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      rst = 1'b1;
      #1;
      chk("boot_state", 32'(dbg_state), 32'd0);
      chk("boot_no_req", 32'(bus.imem_req_valid), 32'd0);
      tick(1);
      chk("run_state", 32'(dbg_state), 32'd1);
      chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("first_req_addr", bus.imem_req_addr, 32'h0001_0000);
      tick(12);
      exp_q = '{32'h0001_0000, 32'h0001_0004, 32'h0001_0008};
      chk_log("stream_iss", 1'b0);
      chk_log("stream_inst", 1'b1);

      // Decode stall: credits run out at two
      reset_dut();
      bus.inst_ready = 1'b0;
      rst = 1'b1;
      tick(10);
      chk("stall_iss_count", 32'(iss_q.size()), 32'd2);
      chk("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
      chk("stall_inst_pc", bus.inst_pc, 32'h0001_0000);
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
      bus.inst_ready = 1'b1;
      tick(1);
      bus.inst_ready = 1'b0;
      chk("stall_cons_count", 32'(cons_pc_q.size()), 32'd1);
      chk("stall_req_again", 32'(bus.imem_req_valid), 32'd1);
      chk("stall_req_addr", bus.imem_req_addr, 32'h0001_0008);
      chk("stall_next_pc", bus.inst_pc, 32'h0001_0004);

      // Redirect with two requests outstanding
      reset_dut();
      resp_en = 1'b0;
      rst = 1'b1;
      tick(5);
      chk("drain_pre_iss", 32'(iss_q.size()), 32'd2);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0002_0040;
      iss_q.delete();
      tick(1);
      bus.redirect_valid = 1'b0;
      resp_en = 1'b1;
      chk("drain_state0", 32'(dbg_state), 32'd2);
      chk("drain_inst0", 32'(bus.inst_valid), 32'd0);
      tick(1);
      chk("drain_state1", 32'(dbg_state), 32'd2);
      chk("drain_inst1", 32'(bus.inst_valid), 32'd0);
      tick(1);
      chk("drain_done_state", 32'(dbg_state), 32'd1);
      chk("drain_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("drain_req_addr", bus.imem_req_addr, 32'h0002_0040);
      chk("drain_inst2", 32'(bus.inst_valid), 32'd0);
      tick(1);
      chk("drain_inst3", 32'(bus.inst_valid), 32'd0);
      tick(1);
      chk("drain_inst_valid", 32'(bus.inst_valid), 32'd1);
      chk("drain_inst_pc", bus.inst_pc, 32'h0002_0040);
      chk("drain_inst_data", bus.inst_data, ~32'h0002_0040);
      exp_q = '{32'h0002_0040};
      chk_log("drain_iss", 1'b0);

      // Redirect coincident with a handshake and a response
      reset_dut();
      rst = 1'b1;
      tick(2);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0003_0000;
      tick(1);
      bus.redirect_valid = 1'b0;
      chk("coinc_state", 32'(dbg_state), 32'd2);
      chk("coinc_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("coinc_iss_count", 32'(iss_q.size()), 32'd2);
      if (iss_q.size() > 1) chk("coinc_stale_addr", iss_q[1], 32'h0001_0004);
      iss_q.delete();
      tick(1);
      chk("coinc_run_state", 32'(dbg_state), 32'd1);
      chk("coinc_req_addr", bus.imem_req_addr, 32'h0003_0000);
      tick(8);
      exp_q = '{32'h0003_0000};
      chk_log("coinc_iss", 1'b0);
      chk_log("coinc_inst", 1'b1);

      // Redirect to the top of the address space wraps to zero
      reset_dut();
      rst = 1'b1;
      tick(1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      tick(1);
      bus.redirect_valid = 1'b0;
      iss_q.delete();
      tick(12);
      exp_q = '{32'hFFFF_FFFC, 32'h0000_0000};
      chk_log("wrap_iss", 1'b0);
      chk_log("wrap_inst", 1'b1);

      // Asynchronous reset with two requests in flight
      reset_dut();
      resp_en = 1'b0;
      rst = 1'b1;
      tick(5);
      chk("arst_pre_addr", bus.imem_req_addr, 32'h0001_0008);
      chk("arst_pre_state", 32'(dbg_state), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_state", 32'(dbg_state), 32'd0);
      chk("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("arst_req_addr", bus.imem_req_addr, 32'h0001_0000);
      chk("arst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("arst_inst_data", bus.inst_data, 32'h0);
      chk("arst_inst_pc", bus.inst_pc, 32'h0);
      tick(2);
      iss_q.delete();
      cons_pc_q.delete();
      cons_d_q.delete();
      resp_en = 1'b1;
      rst = 1'b1;
      tick(12);
      exp_q = '{32'h0001_0000, 32'h0001_0004};
      chk_log("arst_iss", 1'b0);
      chk_log("arst_inst", 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
